// File: rtl/scarv_cop_pkg.sv
// Shared definitions for the SCARV COP memory-side blocks: memory port
// widths, requester owner encoding and the arbiter lock state encoding.
package scarv_cop_pkg;

    localparam int SCARV_MEM_AW = 32;
    localparam int SCARV_MEM_DW = 32;
    localparam int SCARV_MEM_BW = 4;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_COP = 1'b1;

    // Lock state of the shared port. While a granted request is held off by
    // the memory, the grant is frozen on its owner until it is accepted.
    typedef enum logic [1:0] {
        LK_NONE = 2'b00,
        LK_CPU  = 2'b01,
        LK_COP  = 2'b10
    } lock_state_t;

    // Maps an owner bit onto the matching locked state.
    function automatic lock_state_t lock_for(input logic owner);
        return (owner == OWNER_COP) ? LK_COP : LK_CPU;
    endfunction

endpackage

// File: rtl/scarv_cop_rr_pick.sv
// Two-way requester pick for the shared memory port. Bit 0 of req is the
// CPU, bit 1 the COP. A locked grant always wins; otherwise a single
// requester wins, and a tie is broken by round-robin on last_acc or by fixed
// CPU priority with a COP override (force_cop) from the starvation guard.
module scarv_cop_rr_pick
    import scarv_cop_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic [1:0] req,
    input  logic       last_acc,
    input  logic       force_cop,
    input  logic       lock,
    input  logic       lock_cop,
    output logic       winner
);

    // Winner selection; with no request the CPU is reported but not granted.
    always_comb begin
        winner = OWNER_CPU;
        if (lock) begin
            winner = lock_cop;
        end else begin
            case (req)
                2'b01:   winner = OWNER_CPU;
                2'b10:   winner = OWNER_COP;
                2'b11: begin
                    if (FIXED_PRIO != 0) begin
                        winner = force_cop ? OWNER_COP : OWNER_CPU;
                    end else begin
                        winner = ~last_acc;
                    end
                end
                default: winner = OWNER_CPU;
            endcase
        end
    end

endmodule

// File: rtl/scarv_cop_mem_arbiter.sv
// Shares one word-addressed memory port between the host CPU data port and
// the COP memory port. One requester is granted per transaction, the other
// is stalled, and the response of each accepted transaction is routed back
// to its owner on the following cycle.
//
// Handshake: a requester raises cen with wen/addr/wdata/ben and holds them
// until it sees stall low in the same cycle; that cycle is the accept. The
// response (rdata/error) is valid on the owner's port in the next cycle only.
module scarv_cop_mem_arbiter
    import scarv_cop_pkg::*;
#(
    parameter int FIXED_PRIO   = 0,
    parameter int STARVE_LIMIT = 4,
    parameter int CW           = 3
) (
    input  logic                    g_clk,
    input  logic                    g_resetn,

    input  logic                    cpu_mem_cen,
    input  logic                    cpu_mem_wen,
    input  logic [SCARV_MEM_AW-1:0] cpu_mem_addr,
    input  logic [SCARV_MEM_DW-1:0] cpu_mem_wdata,
    input  logic [SCARV_MEM_BW-1:0] cpu_mem_ben,
    output logic                    cpu_mem_stall,
    output logic [SCARV_MEM_DW-1:0] cpu_mem_rdata,
    output logic                    cpu_mem_error,

    input  logic                    cop_mem_cen,
    input  logic                    cop_mem_wen,
    input  logic [SCARV_MEM_AW-1:0] cop_mem_addr,
    input  logic [SCARV_MEM_DW-1:0] cop_mem_wdata,
    input  logic [SCARV_MEM_BW-1:0] cop_mem_ben,
    output logic                    cop_mem_stall,
    output logic [SCARV_MEM_DW-1:0] cop_mem_rdata,
    output logic                    cop_mem_error,

    output logic                    mem_cen,
    output logic                    mem_wen,
    output logic [SCARV_MEM_AW-1:0] mem_addr,
    output logic [SCARV_MEM_DW-1:0] mem_wdata,
    output logic [SCARV_MEM_BW-1:0] mem_ben,
    input  logic                    mem_stall,
    input  logic [SCARV_MEM_DW-1:0] mem_rdata,
    input  logic                    mem_error,

    output logic                    arb_rsp_valid,
    output logic                    arb_rsp_cop
);

    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [1:0]    req;
    logic          winner;
    logic          grant_cen;
    logic          accept;
    logic          force_cop;
    logic [CW-1:0] starve_cnt;

    lock_state_t   lock_q;
    lock_state_t   lock_d;
    logic          lock;
    logic          lock_cop;

    logic          rsp_valid_q;
    logic          rsp_cop_q;
    logic          last_acc_q;
    logic          rsp_live;

    assign req      = {cop_mem_cen, cpu_mem_cen};
    assign lock     = (lock_q != LK_NONE);
    assign lock_cop = (lock_q == LK_COP);

    scarv_cop_rr_pick #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_pick (
        .req       (req),
        .last_acc  (last_acc_q),
        .force_cop (force_cop),
        .lock      (lock),
        .lock_cop  (lock_cop),
        .winner    (winner)
    );

    // Shared port request: the winner's fields, request suppressed in reset.
    always_comb begin
        grant_cen = 1'b0;
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_ben   = '0;
        if (winner == OWNER_COP) begin
            grant_cen = cop_mem_cen;
            mem_wen   = cop_mem_wen;
            mem_addr  = cop_mem_addr;
            mem_wdata = cop_mem_wdata;
            mem_ben   = cop_mem_ben;
        end else begin
            grant_cen = cpu_mem_cen;
            mem_wen   = cpu_mem_wen;
            mem_addr  = cpu_mem_addr;
            mem_wdata = cpu_mem_wdata;
            mem_ben   = cpu_mem_ben;
        end
        mem_cen = g_resetn & grant_cen;
    end

    assign accept = mem_cen & ~mem_stall;

    // Only the granted side sees the memory stall; everyone else is held off.
    assign cpu_mem_stall = ~(mem_cen & (winner == OWNER_CPU)) | mem_stall;
    assign cop_mem_stall = ~(mem_cen & (winner == OWNER_COP)) | mem_stall;

    // Lock state register.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            lock_q <= LK_NONE;
        end else begin
            lock_q <= lock_d;
        end
    end

    // Lock next state: freeze on a stalled grant, release on accept.
    always_comb begin
        lock_d = lock_q;
        if (mem_cen && mem_stall) begin
            lock_d = lock_for(winner);
        end else if (accept) begin
            lock_d = LK_NONE;
        end
    end

    // Response tracking and round-robin history; last_acc starts on the COP
    // so the first tie goes to the CPU.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            rsp_valid_q <= 1'b0;
            rsp_cop_q   <= OWNER_CPU;
            last_acc_q  <= OWNER_COP;
        end else begin
            rsp_valid_q <= accept;
            if (accept) begin
                rsp_cop_q  <= winner;
                last_acc_q <= winner;
            end
        end
    end

    // Starvation guard, only meaningful with fixed CPU priority.
    if (FIXED_PRIO != 0) begin : g_starve
        logic [CW-1:0] cnt_q;

        // Count CPU wins over a waiting COP, saturate, clear on a COP accept.
        always_ff @(posedge g_clk) begin
            if (!g_resetn) begin
                cnt_q <= '0;
            end else if (accept && (winner == OWNER_COP)) begin
                cnt_q <= '0;
            end else if (accept && cop_mem_cen && (cnt_q != LIMIT)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end

        assign starve_cnt = cnt_q;
    end else begin : g_no_starve
        assign starve_cnt = '0;
    end

    assign force_cop = (FIXED_PRIO != 0) && (starve_cnt == LIMIT);

    // Response routing: only the owner of the previous accept sees data, and
    // nothing is routed while reset is asserted.
    always_comb begin
        rsp_live      = g_resetn & rsp_valid_q;
        cpu_mem_rdata = '0;
        cpu_mem_error = 1'b0;
        cop_mem_rdata = '0;
        cop_mem_error = 1'b0;
        if (rsp_live) begin
            if (rsp_cop_q == OWNER_COP) begin
                cop_mem_rdata = mem_rdata;
                cop_mem_error = mem_error;
            end else begin
                cpu_mem_rdata = mem_rdata;
                cpu_mem_error = mem_error;
            end
        end
        arb_rsp_valid = rsp_live;
        arb_rsp_cop   = g_resetn & rsp_cop_q;
    end

endmodule

// File: tb/tb_scarv_cop_mem_arbiter.sv
// Bench for scarv_cop_mem_arbiter. Instance 0 is round-robin, instance 1 is
// fixed CPU priority with a starvation limit of 4. Every cycle both
// instances are compared against a transaction-level reference model.
module tb_scarv_cop_mem_arbiter;
    import scarv_cop_pkg::*;

    localparam int LIMIT = 4;

    logic        g_clk = 1'b0;
    logic        g_resetn = 1'b0;

    logic [1:0]  cpu_cen, cpu_wen, cpu_stall, cpu_error;
    logic [31:0] cpu_addr [2];
    logic [31:0] cpu_wdata [2];
    logic [3:0]  cpu_ben [2];
    logic [31:0] cpu_rdata [2];
    logic [1:0]  cop_cen, cop_wen, cop_stall, cop_error;
    logic [31:0] cop_addr [2];
    logic [31:0] cop_wdata [2];
    logic [3:0]  cop_ben [2];
    logic [31:0] cop_rdata [2];
    logic [1:0]  mem_cen, mem_wen, mem_stall, mem_error;
    logic [31:0] mem_addr [2];
    logic [31:0] mem_wdata [2];
    logic [3:0]  mem_ben [2];
    logic [31:0] mem_rdata [2];
    logic [1:0]  rsp_valid, rsp_cop;

    // Reference model: owner of a held (stalled) grant, last accepted owner,
    // COP losses since its last win, and the response due this cycle.
    int          m_pend [2];
    int          m_last [2];
    int          m_starve [2];
    bit          m_rsp_valid [2];
    int          m_rsp_owner [2];
    int          win [2];
    int          acc [2];
    int          obs [2];

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q [$];

    typedef struct {
        logic cpu_c;
        logic cop_c;
        logic stall;
        logic e_cen;
        logic e_cop;
        logic e_cpu_stall;
        logic e_cop_stall;
    } vec_t;
    vec_t vecs [7];

    always #5 g_clk = ~g_clk;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        scarv_cop_mem_arbiter #(
            .FIXED_PRIO   (k),
            .STARVE_LIMIT (LIMIT),
            .CW           (3)
        ) u_dut (
            .g_clk         (g_clk),
            .g_resetn      (g_resetn),
            .cpu_mem_cen   (cpu_cen[k]),
            .cpu_mem_wen   (cpu_wen[k]),
            .cpu_mem_addr  (cpu_addr[k]),
            .cpu_mem_wdata (cpu_wdata[k]),
            .cpu_mem_ben   (cpu_ben[k]),
            .cpu_mem_stall (cpu_stall[k]),
            .cpu_mem_rdata (cpu_rdata[k]),
            .cpu_mem_error (cpu_error[k]),
            .cop_mem_cen   (cop_cen[k]),
            .cop_mem_wen   (cop_wen[k]),
            .cop_mem_addr  (cop_addr[k]),
            .cop_mem_wdata (cop_wdata[k]),
            .cop_mem_ben   (cop_ben[k]),
            .cop_mem_stall (cop_stall[k]),
            .cop_mem_rdata (cop_rdata[k]),
            .cop_mem_error (cop_error[k]),
            .mem_cen       (mem_cen[k]),
            .mem_wen       (mem_wen[k]),
            .mem_addr      (mem_addr[k]),
            .mem_wdata     (mem_wdata[k]),
            .mem_ben       (mem_ben[k]),
            .mem_stall     (mem_stall[k]),
            .mem_rdata     (mem_rdata[k]),
            .mem_error     (mem_error[k]),
            .arb_rsp_valid (rsp_valid[k]),
            .arb_rsp_cop   (rsp_cop[k])
        );
    end

    task automatic chk(input int k, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL i%0d_%s: got %h expected %h", k, name, act, exp);
        end
    endtask

    // Who the rules say owns the port this cycle (-1 = nobody).
    function automatic int model_winner(input int k);
        if (!g_resetn) return -1;
        if (m_pend[k] >= 0) return m_pend[k];
        if (cpu_cen[k] && cop_cen[k]) begin
            if (k == 1) return (m_starve[k] >= LIMIT) ? 1 : 0;
            return 1 - m_last[k];
        end
        if (cpu_cen[k]) return 0;
        if (cop_cen[k]) return 1;
        return -1;
    endfunction

    task automatic model_reset(input int k);
        m_pend[k]      = -1;
        m_last[k]      = 1;
        m_starve[k]    = 0;
        m_rsp_valid[k] = 1'b0;
        m_rsp_owner[k] = 0;
        acc[k]         = -1;
        win[k]         = -1;
    endtask

    // Compare every output against the model on the falling edge.
    task automatic sample();
        int   w;
        logic rv;
        @(negedge g_clk);
        for (int k = 0; k < 2; k++) begin
            w      = model_winner(k);
            win[k] = w;
            acc[k] = (w >= 0 && !mem_stall[k]) ? w : -1;
            obs[k] = (cpu_cen[k] && !cpu_stall[k]) ? 0 : ((cop_cen[k] && !cop_stall[k]) ? 1 : -1);
            chk(k, "mem_cen", {31'd0, mem_cen[k]}, {31'd0, w >= 0});
            if (w == 0) begin
                chk(k, "mem_addr", mem_addr[k], cpu_addr[k]);
                chk(k, "mem_wdata", mem_wdata[k], cpu_wdata[k]);
                chk(k, "mem_wen_ben", {27'd0, mem_wen[k], mem_ben[k]}, {27'd0, cpu_wen[k], cpu_ben[k]});
            end else if (w == 1) begin
                chk(k, "mem_addr", mem_addr[k], cop_addr[k]);
                chk(k, "mem_wdata", mem_wdata[k], cop_wdata[k]);
                chk(k, "mem_wen_ben", {27'd0, mem_wen[k], mem_ben[k]}, {27'd0, cop_wen[k], cop_ben[k]});
            end
            chk(k, "cpu_stall", {31'd0, cpu_stall[k]}, {31'd0, (w == 0) ? mem_stall[k] : 1'b1});
            chk(k, "cop_stall", {31'd0, cop_stall[k]}, {31'd0, (w == 1) ? mem_stall[k] : 1'b1});
            rv = g_resetn && m_rsp_valid[k];
            chk(k, "rsp_valid", {31'd0, rsp_valid[k]}, {31'd0, rv});
            if (rv) chk(k, "rsp_cop", {31'd0, rsp_cop[k]}, 32'(m_rsp_owner[k]));
            chk(k, "cpu_rdata", cpu_rdata[k], (rv && m_rsp_owner[k] == 0) ? mem_rdata[k] : 32'd0);
            chk(k, "cop_rdata", cop_rdata[k], (rv && m_rsp_owner[k] == 1) ? mem_rdata[k] : 32'd0);
            chk(k, "cpu_error", {31'd0, cpu_error[k]}, {31'd0, rv && m_rsp_owner[k] == 0 && mem_error[k]});
            chk(k, "cop_error", {31'd0, cop_error[k]}, {31'd0, rv && m_rsp_owner[k] == 1 && mem_error[k]});
        end
    endtask

    // Clock edge: advance the model by one transaction step.
    task automatic advance();
        @(posedge g_clk);
        for (int k = 0; k < 2; k++) begin
            if (!g_resetn) begin
                model_reset(k);
            end else begin
                m_rsp_valid[k] = (acc[k] >= 0);
                if (acc[k] >= 0) begin
                    m_rsp_owner[k] = acc[k];
                    m_last[k]      = acc[k];
                    m_pend[k]      = -1;
                    if (k == 1) begin
                        if (acc[k] == 1) m_starve[k] = 0;
                        else if (cop_cen[k] && m_starve[k] < LIMIT) m_starve[k]++;
                    end
                end else if (win[k] >= 0) begin
                    m_pend[k] = win[k];
                end
            end
        end
        #1;
    endtask

    task automatic req_cpu(input int k, input logic wen, input logic [31:0] addr);
        cpu_cen[k]   = 1'b1;
        cpu_wen[k]   = wen;
        cpu_addr[k]  = addr;
        cpu_wdata[k] = $urandom;
        cpu_ben[k]   = 4'($urandom_range(1, 15));
    endtask

    task automatic req_cop(input int k, input logic wen, input logic [31:0] addr);
        cop_cen[k]   = 1'b1;
        cop_wen[k]   = wen;
        cop_addr[k]  = addr;
        cop_wdata[k] = $urandom;
        cop_ben[k]   = 4'($urandom_range(1, 15));
    endtask

    task automatic idle_all();
        for (int k = 0; k < 2; k++) begin
            cpu_cen[k]   = 1'b0;
            cop_cen[k]   = 1'b0;
            mem_stall[k] = 1'b0;
            mem_error[k] = 1'b0;
        end
    endtask

    task automatic reset_all();
        idle_all();
        g_resetn = 1'b0;
        sample();
        advance();
        g_resetn = 1'b1;
    endtask

    // Random requesters obeying the hold-until-accepted rule.
    task automatic drive_random();
        for (int k = 0; k < 2; k++) begin
            if (cpu_cen[k] && acc[k] == 0) cpu_cen[k] = 1'b0;
            if (cop_cen[k] && acc[k] == 1) cop_cen[k] = 1'b0;
            if (!cpu_cen[k] && $urandom_range(0, 1) == 1) req_cpu(k, 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC);
            if (!cop_cen[k] && $urandom_range(0, 1) == 1) req_cop(k, 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC);
            mem_stall[k] = ($urandom_range(0, 2) == 0);
            mem_rdata[k] = $urandom;
            mem_error[k] = 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] e;
        for (int k = 0; k < 2; k++) begin
            model_reset(k);
            cpu_wen[k] = 1'b0; cpu_addr[k] = '0; cpu_wdata[k] = '0; cpu_ben[k] = '0;
            cop_wen[k] = 1'b0; cop_addr[k] = '0; cop_wdata[k] = '0; cop_ben[k] = '0;
            mem_rdata[k] = 32'hA5A5_0000 + 32'(k);
        end
        idle_all();

        //             cpu  cop  stl  cen  cop  cpuS copS
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

        // Reset values.
        reset_all();
        sample();
        for (int k = 0; k < 2; k++) begin
            chk(k, "reset_rsp_cop", {31'd0, rsp_cop[k]}, 32'd0);
            chk(k, "reset_mem_cen", {31'd0, mem_cen[k]}, 32'd0);
        end
        advance();

        // Single-cycle grant table from the reset state.
        for (int i = 0; i < 7; i++) begin
            reset_all();
            for (int k = 0; k < 2; k++) begin
                cpu_cen[k] = vecs[i].cpu_c; cpu_addr[k] = 32'h1000 + 32'(4 * i);
                cop_cen[k] = vecs[i].cop_c; cop_addr[k] = 32'h2000 + 32'(4 * i);
                mem_stall[k] = vecs[i].stall;
            end
            sample();
            for (int k = 0; k < 2; k++) begin
                chk(k, "tbl_cen", {31'd0, mem_cen[k]}, {31'd0, vecs[i].e_cen});
                chk(k, "tbl_cpu_stall", {31'd0, cpu_stall[k]}, {31'd0, vecs[i].e_cpu_stall});
                chk(k, "tbl_cop_stall", {31'd0, cop_stall[k]}, {31'd0, vecs[i].e_cop_stall});
                if (vecs[i].e_cen) chk(k, "tbl_addr", mem_addr[k], vecs[i].e_cop ? cop_addr[k] : cpu_addr[k]);
            end
            advance();
        end

        // CPU read alone, data routed only to the CPU.
        reset_all();
        req_cpu(0, 1'b0, 32'h100);
        sample();
        chk(0, "t1_accept", 32'(obs[0]), 32'd0);
        advance();
        cpu_cen[0] = 1'b0;
        mem_rdata[0] = 32'hDEADBEEF;
        sample();
        chk(0, "t1_cpu_rdata", cpu_rdata[0], 32'hDEADBEEF);
        chk(0, "t1_cop_rdata", cop_rdata[0], 32'd0);
        advance();

        // Round-robin alternation with continuous requests.
        reset_all();
        req_cpu(0, 1'b0, 32'h200);
        req_cop(0, 1'b0, 32'h400);
        exp_q = {};
        for (int i = 0; i < 4; i++) exp_q.push_back(32'(i % 2));
        for (int i = 0; i < 4; i++) begin
            sample();
            e = exp_q.pop_front();
            chk(0, "t2_owner", 32'(obs[0]), e);
            if (i > 0) chk(0, "t2_rsp_cop", {31'd0, rsp_cop[0]}, 32'((i - 1) % 2));
            advance();
            if (acc[0] == 0) cpu_addr[0] += 32'd4;
            else if (acc[0] == 1) cop_addr[0] += 32'd4;
        end
        sample();
        chk(0, "t2_rsp_cop_last", {31'd0, rsp_cop[0]}, 32'd1);
        advance();

        // COP stalled for three cycles while the CPU also requests.
        reset_all();
        mem_stall[0] = 1'b1;
        req_cop(0, 1'b0, 32'h500);
        sample();
        chk(0, "t3_no_accept", 32'(obs[0]), 32'hFFFF_FFFF);
        advance();
        req_cpu(0, 1'b0, 32'h600);
        for (int i = 1; i < 3; i++) begin
            sample();
            chk(0, "t3_addr", mem_addr[0], 32'h500);
            chk(0, "t3_cpu_stall", {31'd0, cpu_stall[0]}, 32'd1);
            advance();
        end
        mem_stall[0] = 1'b0;
        sample();
        chk(0, "t3_cop_accept", 32'(obs[0]), 32'd1);
        chk(0, "t3_cpu_stall_acc", {31'd0, cpu_stall[0]}, 32'd1);
        advance();
        cop_cen[0] = 1'b0;
        sample();
        chk(0, "t3_cpu_accept", 32'(obs[0]), 32'd0);
        advance();
        cpu_cen[0] = 1'b0;

        // Fixed priority with starvation guard: four CPU wins then one COP.
        reset_all();
        req_cpu(1, 1'b0, 32'h3000);
        req_cop(1, 1'b1, 32'h4000);
        exp_q = {};
        for (int i = 0; i < 15; i++) exp_q.push_back((i % 5 == 4) ? 32'd1 : 32'd0);
        for (int i = 0; i < 15; i++) begin
            sample();
            e = exp_q.pop_front();
            chk(1, "t4_owner", 32'(obs[1]), e);
            advance();
            if (acc[1] == 0) cpu_addr[1] += 32'd4;
            else if (acc[1] == 1) cop_addr[1] += 32'd4;
        end

        // COP write with an error response.
        reset_all();
        req_cop(0, 1'b1, 32'h700);
        sample();
        chk(0, "t5_cop_accept", 32'(obs[0]), 32'd1);
        advance();
        cop_cen[0] = 1'b0;
        req_cpu(0, 1'b0, 32'h704);
        mem_error[0] = 1'b1;
        sample();
        chk(0, "t5_cop_error", {31'd0, cop_error[0]}, 32'd1);
        chk(0, "t5_cpu_error", {31'd0, cpu_error[0]}, 32'd0);
        chk(0, "t5_next_accept", 32'(obs[0]), 32'd0);
        advance();
        cpu_cen[0] = 1'b0;
        mem_error[0] = 1'b0;

        // Reset in the response cycle of a CPU read.
        reset_all();
        req_cpu(0, 1'b0, 32'h800);
        sample();
        chk(0, "t6_accept", 32'(obs[0]), 32'd0);
        advance();
        g_resetn = 1'b0;
        mem_rdata[0] = 32'h12345678;
        req_cpu(0, 1'b0, 32'h804);
        sample();
        chk(0, "t6_rdata", cpu_rdata[0], 32'd0);
        chk(0, "t6_rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
        chk(0, "t6_mem_cen", {31'd0, mem_cen[0]}, 32'd0);
        chk(0, "t6_stalls", {30'd0, cpu_stall[0], cop_stall[0]}, 32'd3);
        advance();
        g_resetn = 1'b1;
        sample();
        chk(0, "t6_after_reset", 32'(obs[0]), 32'd0);
        advance();
        cpu_cen[0] = 1'b0;
        mem_rdata[0] = 32'h0BADF00D;
        sample();
        chk(0, "t6_rdata_after", cpu_rdata[0], 32'h0BADF00D);
        advance();

        // Random traffic on both instances against the model.
        reset_all();
        for (int i = 0; i < 400; i++) begin
            drive_random();
            sample();
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
